// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for a word-organised data RAM.
// Takes one request at a time. Loads read the word and return the extended lane.
// SW writes directly. SB/SH read the word, merge the new lane, then write it back.
// Byte lanes are big-endian: byte 0 lives in bits [31:24].
module mem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam logic [31:0] MEM_WORDS_C = 32'(MEM_WORDS);

  // Big-endian byte lane k = bits [31-8k -: 8].
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] off);
    case (off)
      2'd0:    get_byte = word[31:24];
      2'd1:    get_byte = word[23:16];
      2'd2:    get_byte = word[15:8];
      2'd3:    get_byte = word[7:0];
      default: get_byte = 8'h00;
    endcase
  endfunction

  // Loads return the selected lane, sign- or zero-extended; LW returns the whole word.
  function automatic logic [31:0] load_ext(input logic [2:0] o, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = get_byte(word, off);
    h = off[1] ? word[15:0] : word[31:16];
    case (o)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LW:   load_ext = word;
      OP_LBU:  load_ext = {24'h000000, b};
      OP_LHU:  load_ext = {16'h0000, h};
      default: load_ext = 32'h0000_0000;
    endcase
  endfunction

  // Sub-word store merge: only the addressed lane changes.
  function automatic logic [31:0] merge_store(input logic [2:0] o, input logic [1:0] off,
                                              input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    case (o)
      OP_SB: begin
        case (off)
          2'd0:    m[31:24] = wd[7:0];
          2'd1:    m[23:16] = wd[7:0];
          2'd2:    m[15:8]  = wd[7:0];
          2'd3:    m[7:0]   = wd[7:0];
          default: m = word;
        endcase
      end
      OP_SH: begin
        if (off[1]) m[15:0]  = wd;
        else        m[31:16] = wd;
      end
      default: m = word;
    endcase
    merge_store = m;
  endfunction

  function automatic logic is_load_f(input logic [2:0] o);
    case (o)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_f = 1'b1;
      default:                             is_load_f = 1'b0;
    endcase
  endfunction

  // Misalignment for the access width, or a word index past the end of RAM.
  function automatic logic is_fault_f(input logic [2:0] o, input logic [31:0] a);
    logic misal;
    case (o)
      OP_LH, OP_LHU, OP_SH: misal = a[0];
      OP_LW, OP_SW:         misal = (a[1:0] != 2'b00);
      default:              misal = 1'b0;
    endcase
    is_fault_f = misal | ({2'b00, a[31:2]} >= MEM_WORDS_C);
  endfunction

  logic [1:0]  state_r;
  logic [2:0]  op_r;
  logic [1:0]  off_r;
  logic [15:0] wdata_r;

  logic        accept_s;
  logic        fault_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  assign accept_s    = req_valid & req_ready;
  assign fault_s     = is_fault_f(op, addr);
  assign load_data_s = load_ext(op_r, off_r, mem_rdata);
  assign merged_s    = merge_store(op_r, off_r, mem_rdata, wdata_r);

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 3'b000;
      off_r      <= 2'b00;
      wdata_r    <= 16'h0000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      rdata      <= 32'h0000_0000;
      fault      <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r      <= op;
            off_r     <= addr[1:0];
            wdata_r   <= wdata[15:0];
            req_ready <= 1'b0;
            if (fault_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              rdata      <= 32'h0000_0000;
              fault      <= 1'b1;
            end else begin
              mem_addr <= {addr[31:2], 2'b00};
              if (op == OP_SW) begin
                state_r   <= WR;
                mem_wdata <= wdata;
                MemWrite  <= 1'b1;
              end else begin
                state_r <= RD;
                MemRead <= 1'b1;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          MemRead <= 1'b0;
          if (is_load_f(op_r)) begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
            rdata      <= load_data_s;
            fault      <= 1'b0;
          end else begin
            state_r   <= WR;
            mem_wdata <= merged_s;
            MemWrite  <= 1'b1;
          end
        end
        WR: begin
          MemWrite   <= 1'b0;
          state_r    <= RESP;
          resp_valid <= 1'b1;
          rdata      <= 32'h0000_0000;
          fault      <= 1'b0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          MemRead    <= 1'b0;
          MemWrite   <= 1'b0;
        end
      endcase
    end
  end

endmodule
